modbus_rtu_framer: RTL and testbench
====================================

# modbus_rtu_framer

Modbus RTU receive framer sitting between the UART receiver and the Modbus register/command decoder of `top_modbus_converter`. It takes the UART byte stream and finds frame boundaries from inter-character silence (t1.5 / t3.5). It checks CRC-16, address and length, buffers the frame, and presents accepted frames to the decoder through a valid/ack handshake with random-access byte reads. Rejected frames are dropped silently and counted.

## Interface
- `T15_CYC`, default 85938: t1.5 in PCLK cycles (100 MHz, 19200 baud).
- `T35_CYC`, default 200521: t3.5 in PCLK cycles. Must be greater than `T15_CYC`.
- `MAX_LEN`, default 256: buffer depth in bytes, and the maximum frame length.

Ports:
- `PCLK`  in  1  clock; all logic is on the rising edge.
- `PRESETn`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe: a new byte from the UART.
- `rx_data`  in  8  received byte, qualified by `rx_valid`.
- `rx_err`  in  1  framing/parity error, qualified by `rx_valid`.
- `my_addr`  in  8  slave address; must be in the range 1..247.
- `frm_valid`  out  1  an accepted frame is held in the buffer.
- `frm_len`  out  9  frame length in bytes, including the address byte and the 2 CRC bytes.
- `frm_ack`  in  1  decoder has finished with the frame; the buffer is released.
- `frm_rd_addr`  in  8  buffer read index.
- `frm_rd_data`  out  8  registered read data; valid 1 cycle after `frm_rd_addr`.
- `err_cnt`  out  16  count of rejected frames; saturates at 0xFFFF.
- `drop_cnt`  out  16  count of bytes ignored in WAIT/HOLD; saturates at 0xFFFF.

## Operation
- Silence counter `sil` (24 bits):
  - cleared on every `rx_valid`;
  - otherwise increments by 1 each cycle;
  - saturates at `T35_CYC`.
- Per-frame flags: `bad` (sticky), byte count `len`, and running CRC `crc`.
- CRC is Modbus CRC-16:
  - init 0xFFFF, reflected polynomial 0xA001, LSB first;
  - one full byte is processed per cycle (8 unrolled steps);
  - it runs over every byte, CRC bytes included;
  - a good frame leaves a residue of 0x0000.

States:
- **WAIT** (entered on reset): every `rx_valid` increments `drop_cnt`. Go to IDLE when `sil == T35_CYC`.
- **IDLE**: on `rx_valid`:
  - write the byte to buffer[0] and set `len` = 1;
  - `crc` = update(0xFFFF, byte);
  - set `bad` = `rx_err`;
  - go to RECV.
- **RECV**: on `rx_valid`:
  - write the byte to buffer[`len`], `len`++, update `crc`;
  - `bad` |= `rx_err`;
  - if `len == MAX_LEN` already, the byte is not stored and `bad` is set (overflow).
  - When `sil == T15_CYC`, go to GAP.
- **GAP**:
  - `rx_valid` here is a t1.5 violation: set `bad`, drop the byte, go to WAIT. The frame is discarded and `err_cnt`++.
  - When `sil == T35_CYC`, evaluate the frame.
  - Accept if all of: `!bad`, `len >= 4`, `crc == 0`, and buffer[0] equals `my_addr` or 0x00 (broadcast).
  - Accept → HOLD with `frm_valid` = 1. Reject → IDLE with `err_cnt`++.
  - A frame that is only an address mismatch with a good CRC is not an error: go to IDLE and leave `err_cnt` unchanged.
- **HOLD**:
  - `frm_valid` = 1; `frm_len` is stable.
  - `rx_valid` is dropped and `drop_cnt`++.
  - On `frm_ack`: go to WAIT with `frm_valid` = 0. This re-syncs on t3.5, because a frame arriving during HOLD was lost.
- Counter priority: if an error and a drop occur in the same cycle, both counters update.

## Timing
- Reset values: `frm_valid` = 0, `frm_len` = 0, `frm_rd_data` = 0, `err_cnt` = 0, `drop_cnt` = 0; state = WAIT; `sil` = 0.
- Reset mid-frame aborts the frame with no counter update. The block re-enters WAIT.
- With the last byte sampled at edge N:
  - GAP is entered at edge N+`T15_CYC`;
  - `frm_valid` rises at edge N+`T35_CYC`.
- `frm_ack` is sampled only in HOLD. `frm_valid` falls at the edge that samples `frm_ack`; an ack outside HOLD is ignored.
- `frm_rd_data` updates 1 cycle after `frm_rd_addr` in every state. Contents are defined only while `frm_valid` = 1.
- `rx_valid` on the same edge that `sil` reaches a threshold: the byte wins. The counter clears and there is no state transition on that edge.
- `frm_len` holds its value after `frm_ack` until the next accepted frame.

## Test plan
All scenarios use `T15_CYC` = 30, `T35_CYC` = 70, `my_addr` = 0x01, and a byte every 10 cycles unless stated otherwise.

1. Wait 70 cycles after reset, then send 01 03 00 00 00 01 84 0A. Expect `frm_valid` at last byte + 70 cycles, `frm_len` = 8, and reads of index 0..7 returning those bytes. Pulse `frm_ack` → `frm_valid` = 0.
2. Same frame with the last byte 0x0B → no `frm_valid`, `err_cnt` = 1.
3. Same frame with a 40-cycle gap before byte 5 (t1.5 violation) → no `frm_valid`, `err_cnt` = 1, WAIT entered, byte 5 not stored.
4. Address 0x02 with a valid CRC → no `frm_valid`, `err_cnt` = 0. Address 0x00 (broadcast) with a valid CRC → `frm_valid` = 1.
5. Bytes during the 70 cycles after reset, and 3 bytes during HOLD → `drop_cnt` = number of bytes sent; the held frame contents are unchanged.
6. 257-byte stream → overflow; frame rejected with `err_cnt`++. A 3-byte frame with a correct CRC is rejected as too short.

Source files
------------

// File: rtl/modbus_rtu_framer.sv
// Modbus RTU receive framer.
// Splits the UART byte stream into frames using inter-character silence
// (t1.5 closes a frame, t3.5 marks the bus idle), checks the CRC-16, length
// and slave address, and holds an accepted frame for the command decoder.
// Rejected frames are dropped and counted in err_cnt. Bytes that arrive
// while the framer is re-synchronising or holding a frame are counted in
// drop_cnt.
//
// Decoder handshake: frm_valid rises when an accepted frame is in the buffer
// and stays high, with frm_len and the buffer contents stable, until frm_ack
// is sampled high on a rising PCLK edge. frm_valid falls on that same edge.
// frm_ack is ignored while frm_valid is low. Reads are random access:
// frm_rd_data returns buffer[frm_rd_addr] one cycle after the address is
// presented. MAX_LEN is intended to be at most 256, the range of frm_rd_addr.
module modbus_rtu_framer #(
    parameter int unsigned T15_CYC = 85938,
    parameter int unsigned T35_CYC = 200521,
    parameter int unsigned MAX_LEN = 256
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_err,
    input  logic [7:0]  my_addr,
    output logic        frm_valid,
    output logic [8:0]  frm_len,
    input  logic        frm_ack,
    input  logic [7:0]  frm_rd_addr,
    output logic [7:0]  frm_rd_data,
    output logic [15:0] err_cnt,
    output logic [15:0] drop_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RECV = 3'd2,
        ST_GAP  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [23:0] T15     = 24'(T15_CYC);
    localparam logic [23:0] T35     = 24'(T35_CYC);
    localparam logic [8:0]  LEN_MAX = 9'(MAX_LEN);
    localparam logic [8:0]  LEN_MIN = 9'd4;

    // Modbus CRC-16 over one byte: reflected poly 0xA001, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ 16'hA001;
            else      c = c >> 1;
        end
        return c;
    endfunction

    state_t         state_q;
    state_t         state_d;
    logic [23:0]    sil_q;
    logic [23:0]    sil_nxt;
    logic           t15_hit;
    logic           t35_hit;
    logic [8:0]     len_q;
    logic [15:0]    crc_q;
    logic           bad_q;
    logic [7:0]     addr_q;
    logic           shape_ok;
    logic           addr_ok;
    logic           start_frame;
    logic           add_byte;
    logic           accept;
    logic           err_inc;
    logic           drop_inc;
    logic           buf_we;
    logic [AW-1:0]  buf_widx;
    logic [AW-1:0]  rd_idx;
    logic [7:0]     mem [MAX_LEN];

    assign dbg_state = state_q;
    assign frm_valid = (state_q == ST_HOLD);
    assign rd_idx    = AW'(frm_rd_addr);

    // Silence counter: cleared by a byte, otherwise counts up and saturates at t3.5.
    always_comb begin
        sil_nxt = sil_q + 24'd1;
        if (rx_valid)          sil_nxt = 24'd0;
        else if (sil_q >= T35) sil_nxt = T35;
    end

    // Thresholds are judged on the value the counter takes at this edge, so
    // the transition lands exactly T15/T35 edges after the last byte. A byte
    // on that edge forces sil_nxt to zero, so the byte wins.
    assign t15_hit = (sil_nxt == T15);
    assign t35_hit = (sil_nxt == T35);

    // Frame verdict inputs; an address mismatch alone is not an error.
    assign shape_ok = !bad_q && (len_q >= LEN_MIN) && (crc_q == 16'h0000);
    assign addr_ok  = (addr_q == my_addr) || (addr_q == 8'h00);

    // Silence counter register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) sil_q <= 24'd0;
        else          sil_q <= sil_nxt;
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= ST_WAIT;
        else          state_q <= state_d;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        add_byte    = 1'b0;
        accept      = 1'b0;
        err_inc     = 1'b0;
        drop_inc    = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (rx_valid)     drop_inc = 1'b1;
                else if (t35_hit) state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (rx_valid) begin
                    start_frame = 1'b1;
                    state_d     = ST_RECV;
                end
            end
            ST_RECV: begin
                if (rx_valid)     add_byte = 1'b1;
                else if (t15_hit) state_d  = ST_GAP;
            end
            ST_GAP: begin
                if (rx_valid) begin
                    // Byte inside the t1.5..t3.5 window: frame is corrupt, resync.
                    err_inc = 1'b1;
                    state_d = ST_WAIT;
                end else if (t35_hit) begin
                    if (shape_ok && addr_ok) begin
                        accept  = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        err_inc = !shape_ok;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (rx_valid) drop_inc = 1'b1;
                // Anything that arrived while holding was lost, so resync on t3.5.
                if (frm_ack)  state_d  = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Buffer write port: byte 0 on frame start, then append until full.
    always_comb begin
        buf_we   = start_frame || (add_byte && (len_q != LEN_MAX));
        buf_widx = start_frame ? '0 : len_q[AW-1:0];
    end

    // Per-frame accumulators: length, running CRC, sticky bad flag, address byte.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            len_q  <= 9'd0;
            crc_q  <= 16'hFFFF;
            bad_q  <= 1'b0;
            addr_q <= 8'h00;
        end else if (start_frame) begin
            len_q  <= 9'd1;
            crc_q  <= crc16_byte(16'hFFFF, rx_data);
            bad_q  <= rx_err;
            addr_q <= rx_data;
        end else if (add_byte) begin
            crc_q <= crc16_byte(crc_q, rx_data);
            bad_q <= bad_q | rx_err | (len_q == LEN_MAX);
            if (len_q != LEN_MAX) len_q <= len_q + 9'd1;
        end
    end

    // Frame buffer storage.
    always_ff @(posedge PCLK) begin
        if (buf_we) mem[buf_widx] <= rx_data;
    end

    // Registered random-access read port, active in every state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) frm_rd_data <= 8'h00;
        else          frm_rd_data <= mem[rd_idx];
    end

    // Accepted length, held until the next accepted frame.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)    frm_len <= 9'd0;
        else if (accept) frm_len <= len_q;
    end

    // Saturating error and drop counters; both may step in the same cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (err_inc && (err_cnt != 16'hFFFF))   err_cnt  <= err_cnt + 16'd1;
            if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_modbus_rtu_framer.sv
// Bench for modbus_rtu_framer: directed scenarios plus randomized frames,
// checked against a frame-level line model built from inter-byte gaps.
module tb_modbus_rtu_framer;

    localparam int T15  = 30;
    localparam int T35  = 70;
    localparam int MAXL = 256;

    // Line model modes (frame level, not the DUT encoding).
    localparam int LINE_SYNC  = 0;
    localparam int LINE_READY = 1;
    localparam int LINE_FRAME = 2;
    localparam int LINE_HELD  = 3;

    logic        PCLK;
    logic        PRESETn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_err;
    logic [7:0]  my_addr;
    logic        frm_valid;
    logic [8:0]  frm_len;
    logic        frm_ack;
    logic [7:0]  frm_rd_addr;
    logic [7:0]  frm_rd_data;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;
    logic [2:0]  dbg_state;

    modbus_rtu_framer #(
        .T15_CYC(T15),
        .T35_CYC(T35),
        .MAX_LEN(MAXL)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_err(rx_err),
        .my_addr(my_addr),
        .frm_valid(frm_valid),
        .frm_len(frm_len),
        .frm_ack(frm_ack),
        .frm_rd_addr(frm_rd_addr),
        .frm_rd_data(frm_rd_data),
        .err_cnt(err_cnt),
        .drop_cnt(drop_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int t_last = 0;
    int rise_cyc = 0;
    bit rise_seen = 0;
    bit prev_valid = 0;

    // ---------------- model / scoreboard state ----------------
    int         line = LINE_SYNC;
    logic [7:0] cur_q[$];
    bit         cur_bad;
    logic [7:0] exp_q[$];
    int         exp_err, exp_drop, exp_len, exp_rise;
    bit         exp_valid;
    logic [7:0] tx_q[$];
    bit         txe_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {8'h00, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    // One clock edge; sample 1 ns later and note frm_valid rising edges.
    task automatic tick();
        @(posedge PCLK);
        cyc++;
        #1;
        if (frm_valid && !prev_valid) begin
            rise_seen = 1;
            rise_cyc  = cyc;
        end
        prev_valid = frm_valid;
    endtask

    task automatic model_start(input logic [7:0] b, input bit e);
        cur_q.delete();
        cur_q.push_back(b);
        cur_bad = e;
        line    = LINE_FRAME;
    endtask

    // Verdict for the frame collected so far (called once t3.5 of silence passed).
    task automatic model_eval();
        logic [15:0] c;
        bit shape_ok;
        c = 16'hFFFF;
        foreach (cur_q[i]) c = crc_step(c, cur_q[i]);
        shape_ok = !cur_bad && (cur_q.size() >= 4) && (c == 16'h0000);
        if (shape_ok && (cur_q[0] == my_addr || cur_q[0] == 8'h00)) begin
            line      = LINE_HELD;
            exp_valid = 1;
            exp_q     = cur_q;
            exp_len   = cur_q.size();
            exp_rise  = t_last + T35;
        end else begin
            line = LINE_READY;
            if (!shape_ok) exp_err++;
        end
    endtask

    // A byte arriving d edges after the previous byte (or reset release).
    task automatic model_byte(input logic [7:0] b, input bit e, input int d);
        if (line == LINE_FRAME && d > T35) model_eval();
        case (line)
            LINE_SYNC:  if (d > T35) model_start(b, e); else exp_drop++;
            LINE_READY: model_start(b, e);
            LINE_FRAME: begin
                if (d <= T15) begin
                    if (cur_q.size() < MAXL) cur_q.push_back(b);
                    else                     cur_bad = 1;
                    cur_bad = cur_bad | e;
                end else begin
                    exp_err++;
                    line = LINE_SYNC;
                end
            end
            default:    exp_drop++;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input bit e, input int d);
        while (cyc < t_last + d - 1) tick();
        rx_valid = 1;
        rx_data  = b;
        rx_err   = e;
        tick();
        rx_valid = 0;
        rx_err   = 0;
        model_byte(b, e, cyc - t_last);
        t_last = cyc;
    endtask

    task automatic send_tx(input int first_gap, input int lo, input int hi);
        for (int i = 0; i < tx_q.size(); i++)
            send_byte(tx_q[i], txe_q[i], (i == 0) ? first_gap : int'($urandom_range(hi, lo)));
    endtask

    task automatic build_tx(input logic [7:0] addr, input int plen, input bit good);
        logic [15:0] c;
        int idx;
        tx_q.delete();
        txe_q.delete();
        tx_q.push_back(addr);
        for (int i = 0; i < plen; i++) tx_q.push_back(8'($urandom_range(255, 0)));
        c = 16'hFFFF;
        foreach (tx_q[i]) c = crc_step(c, tx_q[i]);
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
        if (!good) begin
            idx = $urandom_range(tx_q.size() - 1, 0);
            tx_q[idx] = tx_q[idx] ^ 8'(1 << $urandom_range(7, 0));
        end
        foreach (tx_q[i]) txe_q.push_back(1'b0);
    endtask

    task automatic load_ref_frame(input logic [7:0] last);
        tx_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        tx_q[7] = last;
        txe_q.delete();
        foreach (tx_q[i]) txe_q.push_back(1'b0);
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
        if (line == LINE_FRAME && (cyc - t_last) >= T35) model_eval();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":valid"}, 32'(frm_valid), 32'(exp_valid));
        chk({tag, ":seen"}, 32'(rise_seen), 32'(exp_valid));
        chk({tag, ":err_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, ":drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
        chk({tag, ":frm_len"}, 32'(frm_len), 32'(exp_len));
        if (exp_valid) begin
            chk({tag, ":rise_at"}, rise_seen ? 32'(rise_cyc) : 32'hFFFF_FFFF, 32'(exp_rise));
            for (int i = 0; i < exp_q.size(); i++) begin
                frm_rd_addr = 8'(i);
                tick();
                chk({tag, ":rd"}, 32'(frm_rd_data), 32'(exp_q[i]));
            end
        end
    endtask

    task automatic do_ack();
        frm_ack = 1;
        tick();
        frm_ack = 0;
        if (line == LINE_HELD) begin
            line      = LINE_SYNC;
            exp_valid = 0;
        end
        rise_seen = 0;
        chk("ack:valid", 32'(frm_valid), 32'(exp_valid));
        chk("ack:frm_len", 32'(frm_len), 32'(exp_len));
        tick();
        tick();
    endtask

    task automatic do_reset();
        PRESETn  = 0;
        rx_valid = 0;
        rx_err   = 0;
        frm_ack  = 0;
        tick();
        tick();
        PRESETn    = 1;
        t_last     = cyc;
        line       = LINE_SYNC;
        exp_err    = 0;
        exp_drop   = 0;
        exp_len    = 0;
        exp_valid  = 0;
        rise_seen  = 0;
        prev_valid = 0;
        cur_bad    = 0;
        cur_q.delete();
        #1;
        chk("rst:valid", 32'(frm_valid), 32'd0);
        chk("rst:frm_len", 32'(frm_len), 32'd0);
        chk("rst:rd_data", 32'(frm_rd_data), 32'd0);
        chk("rst:err_cnt", 32'(err_cnt), 32'd0);
        chk("rst:drop_cnt", 32'(drop_cnt), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] addr;
        int pick, viol, d;
        PRESETn     = 0;
        rx_valid    = 0;
        rx_data     = 8'h00;
        rx_err      = 0;
        frm_ack     = 0;
        my_addr     = 8'h01;
        frm_rd_addr = 8'h00;
        do_reset();

        // Bytes inside the first t3.5 after reset are dropped.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(255, 0)), 0, 10);

        // Reference frame accepted, read back, then bytes during HOLD.
        load_ref_frame(8'h0A);
        send_tx(80, 10, 10);
        settle(T35 + 10);
        check_all("good_frame");
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(255, 0)), 0, $urandom_range(20, 1));
        check_all("hold_drop");
        do_ack();

        // Bad CRC.
        load_ref_frame(8'h0B);
        send_tx(80, 10, 10);
        settle(T35 + 10);
        check_all("bad_crc");

        // t1.5 violation before byte 5; remaining bytes land in resync.
        load_ref_frame(8'h0A);
        for (int i = 0; i < tx_q.size(); i++)
            send_byte(tx_q[i], 0, (i == 0) ? 80 : ((i == 4) ? 40 : 10));
        settle(T35 + 10);
        check_all("t15_viol");

        // Foreign address (silent), then broadcast (accepted).
        build_tx(8'h02, 5, 1);
        send_tx(80, 10, 10);
        settle(T35 + 10);
        check_all("other_addr");
        build_tx(8'h00, 5, 1);
        send_tx(80, 10, 10);
        settle(T35 + 10);
        check_all("broadcast");
        do_ack();

        // Overflow, then a too-short frame with valid CRC.
        tx_q.delete();
        txe_q.delete();
        tx_q.push_back(8'h01);
        for (int i = 1; i < MAXL + 1; i++) tx_q.push_back(8'($urandom_range(255, 0)));
        foreach (tx_q[i]) txe_q.push_back(1'b0);
        send_tx(80, 10, 10);
        settle(T35 + 10);
        check_all("overflow");
        build_tx(8'h01, 0, 1);
        send_tx(80, 10, 10);
        settle(T35 + 10);
        check_all("short");

        // Randomized frames: address, length, CRC damage, rx_err, gap violations.
        repeat (30) begin
            pick = $urandom_range(3, 0);
            addr = (pick == 0) ? 8'h01 : (pick == 1) ? 8'h00 : (pick == 2) ? 8'h02 : 8'($urandom_range(255, 0));
            build_tx(addr, $urandom_range(8, 0), $urandom_range(3, 0) != 0);
            if ($urandom_range(9, 0) == 0) txe_q[$urandom_range(tx_q.size() - 1, 0)] = 1'b1;
            viol = ($urandom_range(7, 0) == 0) ? int'($urandom_range(tx_q.size() - 1, 1)) : 0;
            for (int i = 0; i < tx_q.size(); i++) begin
                if (i == 0)         d = $urandom_range(T35 + 30, T35 + 1);
                else if (i == viol) d = $urandom_range(T35, T15 + 1);
                else                d = $urandom_range(T15, 1);
                send_byte(tx_q[i], txe_q[i], d);
            end
            settle(T35 + 5);
            check_all("rnd");
            if (exp_valid) begin
                if ($urandom_range(1, 0) == 1) begin
                    repeat (2) send_byte(8'($urandom_range(255, 0)), 0, $urandom_range(20, 1));
                    check_all("rnd_hold");
                end
                do_ack();
            end else if ($urandom_range(3, 0) == 0) begin
                do_ack();
            end
        end

        // Reset in the middle of a frame.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(255, 0)), 0, (i == 0) ? T35 + 5 : 10);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
